ast_field_source: RTL and testbench

Avalon-ST video source generating raster test packets of WIDTH×HEIGHT beats (progressive) or alternating even/odd fields of WIDTH×HEIGHT/2 beats (interlaced), with SOP/EOP framing and full ready/valid backpressure. Sits at the upstream end of the deinterlacer datapath as the stimulus/bring-up source feeding pipe stages and the deinterlacer core. Pixel contents encode position, so downstream checkers can verify ordering and line selection beat by beat.

---
 rtl/ast_video_pkg.sv | 33 +++
 rtl/ast_raster_counter.sv | 78 +++++++
 rtl/ast_field_source.sv | 157 +++++++++++++++
 tb/tb_ast_field_source.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ast_video_pkg.sv
// Shared types and helpers for the Avalon-ST video source: FSM state
// encoding, data-width derivation and the position-encoding pixel packer.
package ast_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_GAP
  } state_t;

  // Widest beat the packer can build; callers truncate to their own width.
  localparam int MAX_DATA_WIDTH = 256;

  function automatic int data_width(input int symbols_per_beat, input int bits_per_symbol);
    return symbols_per_beat * bits_per_symbol;
  endfunction

  // Symbol 0 = x, symbol 1 = line, symbol 2 = packet count, everything above
  // is zero. Truncating the result drops symbols a narrow beat cannot carry.
  function automatic logic [MAX_DATA_WIDTH-1:0] pack_pixel(
    input logic [31:0] x,
    input logic [31:0] line,
    input logic [31:0] count,
    input int          bits_per_symbol
  );
    logic [MAX_DATA_WIDTH-1:0] mask;
    mask = (MAX_DATA_WIDTH'(1) << bits_per_symbol) - MAX_DATA_WIDTH'(1);
    return (MAX_DATA_WIDTH'(x) & mask)
         | ((MAX_DATA_WIDTH'(line) & mask) << bits_per_symbol)
         | ((MAX_DATA_WIDTH'(count) & mask) << (2 * bits_per_symbol));
  endfunction

endpackage

// File: rtl/ast_raster_counter.sv
// Raster position counter: x/line with wrap, line step of 1 (frame) or 2
// (field), and SOP/EOP flags for the position the counter moves to next.
module ast_raster_counter #(
  parameter int  WIDTH  = 640,
  parameter int  HEIGHT = 480,
  localparam int XW     = $clog2(WIDTH),
  localparam int LW     = $clog2(HEIGHT + 2)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          advance,
  input  logic          interlaced,
  input  logic          odd,
  output logic [XW-1:0] x_next,
  output logic [LW-1:0] line_next,
  output logic          odd_next,
  output logic          interlaced_mode,
  output logic          sop_next,
  output logic          eop_next
);

  localparam logic [XW-1:0] X_LAST      = XW'(WIDTH - 1);
  localparam logic [LW-1:0] L_LAST      = LW'(HEIGHT - 1);
  localparam logic [LW-1:0] L_LAST_EVEN = LW'(HEIGHT - 2);

  logic [XW-1:0] x_q;
  logic [LW-1:0] line_q;
  logic          odd_q;
  logic          mode_next;
  logic [LW-1:0] first_line;
  logic [LW-1:0] last_line;

  // Next position: load restarts the raster, advance steps it by one beat.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    mode_next = interlaced_mode;
    odd_next  = odd_q;
    x_next    = x_q;
    line_next = line_q;
    if (load) begin
      mode_next = interlaced;
      odd_next  = interlaced & odd;
      x_next    = '0;
      line_next = {{(LW-1){1'b0}}, interlaced & odd};
    end else if (advance) begin
      if (x_q == X_LAST) begin
        x_next    = '0;
        line_next = line_q + (interlaced_mode ? LW'(2) : LW'(1));
      end else begin
        x_next = x_q + XW'(1);
      end
    end
    first_line = {{(LW-1){1'b0}}, odd_next};
    last_line  = (mode_next && !odd_next) ? L_LAST_EVEN : L_LAST;
    sop_next   = (x_next == '0) && (line_next == first_line);
    eop_next   = (x_next == X_LAST) && (line_next == last_line);
  end

  // Position and packet-mode registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q             <= '0;
      line_q          <= '0;
      odd_q           <= 1'b0;
      interlaced_mode <= 1'b0;
    end else begin
      x_q             <= x_next;
      line_q          <= line_next;
      odd_q           <= odd_next;
      interlaced_mode <= mode_next;
    end
  end

endmodule

// File: rtl/ast_field_source.sv
// Avalon-ST raster test source: emits progressive frames or alternating
// even/odd fields with SOP/EOP framing, inter-packet gaps and backpressure.
module ast_field_source
  import ast_video_pkg::*;
#(
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int WIDTH            = 640,
  parameter int HEIGHT           = 480,
  parameter int GAP_CYCLES       = 2
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic                                        interlaced,
  output logic [SYMBOLS_PER_BEAT*BITS_PER_SYMBOL-1:0] dout_data,
  input  logic                                        dout_ready,
  output logic                                        dout_valid,
  output logic                                        dout_startofpacket,
  output logic                                        dout_endofpacket,
  output logic                                        field_id,
  output logic                                        packet_done
);

  localparam int DATA_WIDTH = data_width(SYMBOLS_PER_BEAT, BITS_PER_SYMBOL);
  localparam int XW         = $clog2(WIDTH);
  localparam int LW         = $clog2(HEIGHT + 2);

  localparam logic [7:0]                 GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [BITS_PER_SYMBOL-1:0] COUNT_ONE = BITS_PER_SYMBOL'(1);

  state_t                     state_q, state_d;
  logic [7:0]                 gap_q, gap_d;
  logic [BITS_PER_SYMBOL-1:0] count_q, count_d;
  logic                       parity_q, parity_d;
  logic                       load;
  logic                       transfer;
  logic                       eop_transfer;
  logic                       valid_d;
  logic [XW-1:0]              x_next;
  logic [LW-1:0]              line_next;
  logic                       odd_next;
  logic                       interlaced_mode;
  logic                       sop_next;
  logic                       eop_next;
  logic [DATA_WIDTH-1:0]      pixel_next;

  ast_raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clock           (clock),
    .reset           (reset),
    .load            (load),
    .advance         (transfer),
    .interlaced      (interlaced),
    .odd             (parity_d),
    .x_next          (x_next),
    .line_next       (line_next),
    .odd_next        (odd_next),
    .interlaced_mode (interlaced_mode),
    .sop_next        (sop_next),
    .eop_next        (eop_next)
  );

  // Packet sequencing: start on enable, finish on EOP transfer, then gap and
  // re-decide. Parity toggles per field; a finished frame resets it to even.
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    count_d      = count_q;
    parity_d     = parity_q;
    load         = 1'b0;
    transfer     = dout_valid && dout_ready;
    eop_transfer = transfer && dout_endofpacket;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          load    = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (eop_transfer) begin
          count_d  = count_q + COUNT_ONE;
          parity_d = interlaced_mode & ~parity_q;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LAST;
          end else if (enable) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          if (enable) begin
            load    = 1'b1;
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d    = (state_d == ST_ACTIVE);
    pixel_next = DATA_WIDTH'(pack_pixel(32'(x_next), 32'(line_next), 32'(count_d),
                                        BITS_PER_SYMBOL));
  end

  // FSM, gap counter, packet count and field parity.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gap_q    <= 8'd0;
      count_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      count_q  <= count_d;
      parity_q <= parity_d;
    end
  end

  // Registered stream outputs; a stalled beat recomputes to the same values
  // because the raster counter only moves on a transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_valid         <= 1'b0;
      dout_data          <= '0;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
      field_id           <= 1'b0;
      packet_done        <= 1'b0;
    end else begin
      dout_valid  <= valid_d;
      packet_done <= eop_transfer;
      if (valid_d) begin
        dout_data          <= pixel_next;
        dout_startofpacket <= sop_next;
        dout_endofpacket   <= eop_next;
        field_id           <= odd_next;
      end else begin
        dout_data          <= '0;
        dout_startofpacket <= 1'b0;
        dout_endofpacket   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ast_field_source.sv
// Self-checking bench for ast_field_source on a 4x4 raster: a cycle table for
// framing/gaps/parity, then random backpressure, enable drop, mid-packet
// reset and a zero-gap instance.
module tb_ast_field_source;

  typedef struct {
    logic        en;
    logic        il;
    logic        rdy;
    logic        valid;
    logic        sop;
    logic        eop;
    logic        field;
    logic        done;
    logic [23:0] data;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        interlaced = 1'b0;
  logic        dout_ready = 1'b1;
  logic [23:0] dout_data;
  logic        dout_valid, dout_sop, dout_eop, field_id, packet_done;

  logic        enable_b = 1'b0;
  logic        ready_b = 1'b1;
  logic        il_b = 1'b0;
  logic [23:0] data_b;
  logic        valid_b, sop_b, eop_b, field_b, done_b;

  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  always #5 clock = ~clock;

  ast_field_source #(
    .SYMBOLS_PER_BEAT (3),
    .BITS_PER_SYMBOL  (8),
    .WIDTH            (4),
    .HEIGHT           (4),
    .GAP_CYCLES       (2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .enable             (enable),
    .interlaced         (interlaced),
    .dout_data          (dout_data),
    .dout_ready         (dout_ready),
    .dout_valid         (dout_valid),
    .dout_startofpacket (dout_sop),
    .dout_endofpacket   (dout_eop),
    .field_id           (field_id),
    .packet_done        (packet_done)
  );

  ast_field_source #(
    .SYMBOLS_PER_BEAT (3),
    .BITS_PER_SYMBOL  (8),
    .WIDTH            (4),
    .HEIGHT           (4),
    .GAP_CYCLES       (0)
  ) dut_nogap (
    .clock              (clock),
    .reset              (reset),
    .enable             (enable_b),
    .interlaced         (il_b),
    .dout_data          (data_b),
    .dout_ready         (ready_b),
    .dout_valid         (valid_b),
    .dout_startofpacket (sop_b),
    .dout_endofpacket   (eop_b),
    .field_id           (field_b),
    .packet_done        (done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_pixel(input int x, input int line, input int cnt);
    logic [7:0] sx, sl, sc;
    sx = 8'(x);
    sl = 8'(line);
    sc = 8'(cnt);
    return {sc, sl, sx};
  endfunction

  // One packet of ready=1 beats; il_drive is what the interlaced pin does
  // mid-packet (must be ignored).
  task automatic add_packet(input bit mode, input bit odd, input int cnt, input bit il_drive);
    vec_t v;
    int   nlines, step, first;
    nlines = mode ? 2 : 4;
    step   = mode ? 2 : 1;
    first  = (mode && odd) ? 1 : 0;
    for (int l = 0; l < nlines; l++) begin
      for (int x = 0; x < 4; x++) begin
        v.en    = 1'b1;
        v.il    = il_drive;
        v.rdy   = 1'b1;
        v.valid = 1'b1;
        v.sop   = (l == 0) && (x == 0);
        v.eop   = (l == nlines - 1) && (x == 3);
        v.field = mode && odd;
        v.done  = 1'b0;
        v.data  = exp_pixel(x, first + l * step, cnt);
        vecs.push_back(v);
      end
    end
  endtask

  task automatic add_idle(input int n, input bit en, input bit il, input bit first_done);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.en    = en;
      v.il    = il;
      v.rdy   = 1'b1;
      v.valid = 1'b0;
      v.sop   = 1'b0;
      v.eop   = 1'b0;
      v.field = 1'b0;
      v.done  = first_done && (i == 0);
      v.data  = '0;
      vecs.push_back(v);
    end
  endtask

  task automatic do_reset();
    enable     = 1'b0;
    interlaced = 1'b0;
    dout_ready = 1'b1;
    enable_b   = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int n, b, pk, eops, lows;
    bit prev_eop, seen;

    // ---- reset values ----
    repeat (2) @(negedge clock);
    check("rst valid", 32'(dout_valid), 32'd0);
    check("rst data", 32'(dout_data), 32'd0);
    check("rst sop", 32'(dout_sop), 32'd0);
    check("rst eop", 32'(dout_eop), 32'd0);
    check("rst field", 32'(field_id), 32'd0);
    check("rst done", 32'(packet_done), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle valid", 32'(dout_valid), 32'd0);

    // ---- cycle table: 2 frames, 3 fields, then stop ----
    add_idle(1, 1'b1, 1'b0, 1'b0);
    add_packet(1'b0, 1'b0, 0, 1'b1);
    add_idle(2, 1'b1, 1'b0, 1'b1);
    add_packet(1'b0, 1'b0, 1, 1'b0);
    add_idle(2, 1'b1, 1'b1, 1'b1);
    add_packet(1'b1, 1'b0, 2, 1'b1);
    add_idle(2, 1'b1, 1'b1, 1'b1);
    add_packet(1'b1, 1'b1, 3, 1'b1);
    add_idle(2, 1'b1, 1'b1, 1'b1);
    add_packet(1'b1, 1'b0, 4, 1'b0);
    add_idle(2, 1'b0, 1'b0, 1'b1);
    add_idle(3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      enable     = vecs[i].en;
      interlaced = vecs[i].il;
      dout_ready = vecs[i].rdy;
      check($sformatf("vec%0d valid", i), 32'(dout_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d done", i), 32'(packet_done), 32'(vecs[i].done));
      if (vecs[i].valid) begin
        check($sformatf("vec%0d data", i), 32'(dout_data), 32'(vecs[i].data));
        check($sformatf("vec%0d sop", i), 32'(dout_sop), 32'(vecs[i].sop));
        check($sformatf("vec%0d eop", i), 32'(dout_eop), 32'(vecs[i].eop));
        check($sformatf("vec%0d field", i), 32'(field_id), 32'(vecs[i].field));
      end
    end

    // ---- random backpressure over three interlaced fields ----
    do_reset();
    interlaced = 1'b1;
    enable     = 1'b1;
    b  = 0;
    pk = 0;
    for (int cyc = 0; cyc < 2000 && pk < 3; cyc++) begin
      @(negedge clock);
      if (dout_valid) begin
        check("rr data", 32'(dout_data), 32'(exp_pixel(b % 4, (pk % 2) + 2 * (b / 4), pk)));
        check("rr sop", 32'(dout_sop), 32'(b == 0));
        check("rr eop", 32'(dout_eop), 32'(b == 7));
        check("rr field", 32'(field_id), 32'(pk % 2));
      end
      dout_ready = 1'($urandom_range(0, 1));
      if (dout_valid && dout_ready) begin
        if (pk == 2 && b == 0) enable = 1'b0;
        b++;
        if (b == 8) begin
          b = 0;
          pk++;
        end
      end
    end
    check("rr packets", 32'(pk), 32'd3);
    dout_ready = 1'b1;
    lows = 0;
    repeat (8) begin
      @(negedge clock);
      if (dout_valid) lows++;
    end
    check("rr stopped", 32'(lows), 32'd0);

    // ---- enable dropped at beat 5 of a frame ----
    do_reset();
    enable = 1'b1;
    b    = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      @(negedge clock);
      if (dout_valid) begin
        check("drop data", 32'(dout_data), 32'(exp_pixel(b % 4, b / 4, 0)));
        if (b == 5) enable = 1'b0;
        if (dout_eop) seen = 1'b1;
        b++;
      end
    end
    check("drop eop seen", 32'(seen), 32'd1);
    check("drop beats", 32'(b), 32'd16);
    lows = 0;
    repeat (10) begin
      @(negedge clock);
      if (dout_valid) lows++;
    end
    check("drop idle", 32'(lows), 32'd0);

    // ---- reset in the middle of an odd field ----
    do_reset();
    interlaced = 1'b1;
    enable     = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 100 && n < 14; cyc++) begin
      @(negedge clock);
      if (dout_valid) n++;
    end
    check("mid beats", 32'(n), 32'd14);
    check("mid field before", 32'(field_id), 32'd1);
    reset = 1'b1;
    #1;
    check("mid valid", 32'(dout_valid), 32'd0);
    check("mid sop", 32'(dout_sop), 32'd0);
    check("mid data", 32'(dout_data), 32'd0);
    check("mid field", 32'(field_id), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clock);
      if (dout_valid) seen = 1'b1;
    end
    check("post valid", 32'(seen), 32'd1);
    check("post sop", 32'(dout_sop), 32'd1);
    check("post data", 32'(dout_data), 32'd0);
    check("post field", 32'(field_id), 32'd0);

    // ---- zero-gap instance: back-to-back frames ----
    do_reset();
    enable_b = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clock);
      if (valid_b) seen = 1'b1;
    end
    check("ng first sop", 32'(seen && sop_b), 32'd1);
    lows     = 0;
    eops     = 0;
    prev_eop = valid_b && eop_b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!valid_b) lows++;
      if (prev_eop) begin
        check("ng sop after eop", 32'(sop_b), 32'd1);
        check("ng done with sop", 32'(done_b), 32'd1);
        check("ng sop data", 32'(data_b), 32'(exp_pixel(0, 0, eops)));
      end
      if (valid_b && eop_b) eops++;
      prev_eop = valid_b && eop_b;
    end
    check("ng valid low", 32'(lows), 32'd0);
    check("ng eop count", 32'(eops), 32'd2);
    enable_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
